sseg_scan_ctrl: RTL



---
 rtl/sseg_scan_ctrl_pkg.sv | 21 ++
 rtl/sseg_scan_ctrl_if.sv | 42 ++++
 rtl/sseg_scan_ctrl_hex_dec.sv | 36 +++
 rtl/sseg_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg -- shared types and constants for the seven-segment scan controller.
//
// Contents:
//   scan_state_t : scan FSM state (OFF, BLANK, DRIVE)
//   digit_idx_t  : 2-bit index of the digit currently being scanned
//   SSEG_BLANK   : segment pattern with every segment off (active-low)
// -----------------------------------------------------------------------------
package sseg_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SSEG_BLANK = 7'h7F;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl_if -- bundle of the control/data inputs and display outputs of
// the seven-segment scan controller.
//
// Signals:
//   enable      : 1 = scan display, 0 = display dark
//   load        : single-cycle strobe capturing data/dp_in
//   data[15:0]  : four hex digits, [3:0] = digit 0 (rightmost)
//   dp_in[3:0]  : decimal points, 1 = lit, bit i = digit i
//   seg[6:0]    : segments gfedcba, active-low
//   dp          : decimal point, active-low
//   an[3:0]     : anodes, active-low one-hot
//   frame_start : one-cycle pulse at the start of the digit-0 slot
//   pending     : a loaded value is waiting for the next frame boundary
//
// Modports:
//   master : the data path driving the controller
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface sseg_scan_ctrl_if;

    logic        enable;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;

    modport master (
        output enable, load, data, dp_in,
        input  seg, dp, an, frame_start, pending
    );

    modport slave (
        input  enable, load, data, dp_in,
        output seg, dp, an, frame_start, pending
    );

endinterface

// File: rtl/sseg_scan_ctrl_hex_dec.sv
// -----------------------------------------------------------------------------
// sseg_hex_dec -- combinational hex digit to seven-segment decoder.
//
// Ports:
//   hex_i[3:0] : hex digit
//   seg_o[6:0] : segments gfedcba, active-low (0 = segment lit)
// -----------------------------------------------------------------------------
module sseg_hex_dec (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h18;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl -- time-multiplexed controller for a 4-digit, common-anode,
// active-low seven-segment display.
//
// A loaded 16-bit value is shown one hex digit at a time. Every digit slot is
// REFRESH_DIV cycles long: BLANK_CYCLES cycles with all anodes off (ghosting
// suppression) followed by the driven portion. New values are staged in a
// pending register and promoted to the display register at the frame boundary
// (first BLANK cycle of digit 0) so a frame never shows a mix of two values.
//
// Parameters:
//   REFRESH_DIV  : clock cycles per digit slot (>= 4)
//   BLANK_CYCLES : blanked cycles at the start of each slot (1 .. REFRESH_DIV-1)
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : sseg_scan_ctrl_if.slave (enable, load, data, dp_in in;
//           seg, dp, an, frame_start, pending out)
//
// Build option:
//   SSEG_LZ_BLANK_EN : when defined, digits above the most significant nonzero
//                      digit show all segments off (anode still driven);
//                      digit 0 always shows its value.
// -----------------------------------------------------------------------------
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    sseg_scan_ctrl_if.slave  bus
);

    localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  BLANK_LAST = PW'(BLANK_CYCLES - 1);

    scan_state_t   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;

    logic [15:0]   disp_data_q;
    logic [3:0]    disp_dp_q;
    logic [15:0]   pend_data_q;
    logic [3:0]    pend_dp_q;
    logic          pending_q;

    logic [6:0]    seg_q;
    logic          dp_q;
    logic [3:0]    an_q;
    logic          fs_q;

    logic          at_boundary;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic [6:0]    digit_seg;

    // The frame boundary is the cycle in which frame_start is high: the
    // first BLANK cycle of digit 0. Updating the display at the end of this
    // cycle still lands before any anode of the frame is driven.
    assign at_boundary = (state_q == BLANK) && (presc_q == '0) && (idx_q == '0);

    assign cur_digit = disp_data_q[{idx_q, 2'b00} +: 4];

    sseg_hex_dec u_dec (
        .hex_i (cur_digit),
        .seg_o (dec_seg)
    );

`ifdef SSEG_LZ_BLANK_EN
    // lz_blank[i]: digit i and every digit above it are zero.
    logic [3:0] lz_blank;

    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (disp_data_q[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (disp_data_q[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (disp_data_q[7:4] == 4'h0);
    end

    assign digit_seg = lz_blank[idx_q] ? SSEG_BLANK : dec_seg;
`else
    assign digit_seg = dec_seg;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!bus.enable) begin
            state_d = OFF;
            presc_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = BLANK;
                    presc_d = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    presc_d = presc_q + 1'b1;
                    if (presc_q == BLANK_LAST) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (presc_q == PRE_LAST) begin
                        state_d = BLANK;
                        presc_d = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                    presc_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OFF;
            presc_q     <= '0;
            idx_q       <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SSEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
            fs_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            fs_q    <= (state_d == BLANK) && (presc_d == '0) && (idx_d == '0);

            // A load while OFF also drops any stale pending value so it can
            // not overwrite this newer data at the next boundary.
            if (bus.load && ((state_q == OFF) || at_boundary)) begin
                disp_data_q <= bus.data;
                disp_dp_q   <= bus.dp_in;
                pending_q   <= 1'b0;
            end else if (at_boundary && pending_q) begin
                disp_data_q <= pend_data_q;
                disp_dp_q   <= pend_dp_q;
                pending_q   <= 1'b0;
            end else if (bus.load) begin
                pend_data_q <= bus.data;
                pend_dp_q   <= bus.dp_in;
                pending_q   <= 1'b1;
            end

            // Display pins follow the current state one cycle late, except
            // that dropping enable darkens them on the very next edge.
            if ((state_d == OFF) || (state_q != DRIVE)) begin
                an_q  <= 4'hF;
                seg_q <= SSEG_BLANK;
                dp_q  <= 1'b1;
            end else begin
                an_q  <= ~(4'b0001 << idx_q);
                seg_q <= digit_seg;
                dp_q  <= ~disp_dp_q[idx_q];
            end
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;
    assign bus.pending     = pending_q;

endmodule
